aes_ctr_stream: RTL and testbench

- Counter-mode (CTR) wrapper that sits in front of and behind the free-running AES encrypt pipeline.
- Generates one counter block per accepted plaintext block and drives it into the pipeline input.
- Delays the plaintext and its tags to match the pipeline latency, then XORs the returned keystream to produce ciphertext with a valid/last stream.
- The pipeline has no valid or stall, so this block owns all flow tracking.

---
 rtl/aes_ctr_stream.sv | 133 +++++++++++++
 tb/tb_aes_ctr_stream.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: CTR-mode wrapper around a fixed-latency, stall-free AES encrypt pipeline.
// Optional macro AES_CTR_WRAP_ERR_EN: a counter wrap ends the message early and raises err.
module aes_ctr_stream #(
   parameter int LAT   = 11,
   parameter int CTR_W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] iv,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_last,
   output logic [127:0] aes_in,
   input  logic [127:0] aes_out,
   output logic         out_valid,
   output logic [127:0] out_data,
   output logic         out_last,
   output logic         done,
   output logic         busy,
   output logic         err
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [127:0] LOW_MASK = (128'd1 << CTR_W) - 128'd1;

   state_t         state_q, state_d;
   logic [127:0]   ctr_q, ctr_d;
   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] last_q;
   logic [127:0]   data_q [LAT];
   logic [127:0]   outData_q;
   logic           outValid_q, outLast_q;
   logic           accept, pushLast, wrapHit;

   assign in_ready  = (state_q == RUN);
   assign accept    = in_valid & in_ready;
   assign busy      = (state_q != IDLE);
   assign aes_in    = ctr_q;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_last  = outLast_q;
   assign done      = outValid_q & outLast_q;

`ifdef AES_CTR_WRAP_ERR_EN
   logic err_q, err_d;

   // The block that hits the all-ones counter is still sent, but tagged last so done pulses.
   assign wrapHit = accept & ~in_last & ((ctr_q & LOW_MASK) == LOW_MASK);
   assign err     = err_q;

   always_comb begin
      err_d = err_q;
      if ((state_q == IDLE) && start) begin
         err_d = 1'b0;
      end else if (wrapHit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   assign wrapHit = 1'b0;
   assign err     = 1'b0;
`endif

   assign pushLast = in_last | wrapHit;

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               ctr_d   = iv;
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               ctr_d = (ctr_q & ~LOW_MASK) | ((ctr_q + 128'd1) & LOW_MASK);
               if (pushLast) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Only the valid bits need reset; stale pipeline and payload contents are then never used.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ctr_q      <= '0;
         vld_q      <= '0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outLast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctr_q      <= ctr_d;
         vld_q      <= {vld_q[LAT-2:0], accept};
         outValid_q <= vld_q[LAT-1];
         if (vld_q[LAT-1]) begin
            outData_q <= data_q[LAT-1] ^ aes_out;
            outLast_q <= last_q[LAT-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      data_q[0] <= in_data;
      for (int i = 1; i < LAT; i++) begin
         data_q[i] <= data_q[i-1];
      end
      last_q <= {last_q[LAT-2:0], pushLast};
   end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// Self-checking bench for aes_ctr_stream: table-driven messages, hand sequences and random
// traffic, all scored against a message-level model with a stand-in keystream function.
module tb_aes_ctr_stream;

   localparam int LAT   = 11;
   localparam int CTR_W = 32;

   logic         clk = 1'b0;
   logic         rst_n, start, in_valid, in_last;
   logic         in_ready, out_valid, out_last, done, busy, err;
   logic [127:0] iv, in_data, aes_in, aes_out, out_data;

   always #5 clk = ~clk;

   aes_ctr_stream #(.LAT(LAT), .CTR_W(CTR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .iv(iv),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .aes_in(aes_in), .aes_out(aes_out),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .done(done), .busy(busy), .err(err)
   );

   // Stand-in for the AES core: a LAT-deep pipeline applying a fixed keyed mix.
   function automatic logic [127:0] ks(input logic [127:0] x);
      return {x[63:0], x[127:64]} ^ {4{32'h9E3779B9}} ^ (x << 7);
   endfunction

   logic [127:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= ks(aes_in);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign aes_out = pipe[LAT-1];

   typedef enum logic [1:0] {M_IDLE, M_RUN, M_DRAIN} mstate_t;
   typedef struct {
      int           cyc;
      logic [127:0] data;
      logic         last;
   } exp_t;
   typedef struct {
      logic [127:0] iv;
      logic [31:0]  pat;
      int           nv;
      bit           randPt;
      int           expOuts;
      logic [127:0] expEnd;
      logic         expErr;
   } msgVec_t;

   int           errors = 0;
   int           checks = 0;
   int           edgeCnt = 0;
   int           dutOuts = 0;
   bit           chkOn = 0;
   mstate_t      mState = M_IDLE;
   logic [127:0] mCtr = '0;
   logic         mErr = 1'b0;
   logic         mDoneNow = 1'b0;
   logic [127:0] holdData = '0;
   logic         holdLast = 1'b0;
   exp_t         expQ [$];
   msgVec_t      vecs [4];

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edgeCnt);
      end
   endtask

   // One clock: check pre-edge outputs, advance the model, clock, then check registered outputs.
   task automatic applyStimulus();
      logic   acc;
      logic   wrapErr;
      exp_t   e;
      logic [CTR_W-1:0] low;
      if (chkOn) begin
         checkOutput("in_ready", in_ready, mState == M_RUN);
         checkOutput("busy", busy, mState != M_IDLE);
      end
      acc = rst_n && (mState == M_RUN) && in_valid;
      if (acc) begin
         checkOutput("aes_in", aes_in, mCtr);
         low = mCtr[CTR_W-1:0];
         wrapErr = 1'b0;
`ifdef AES_CTR_WRAP_ERR_EN
         wrapErr = (low == {CTR_W{1'b1}}) && !in_last;
`endif
         e.cyc  = edgeCnt + 1 + LAT;
         e.data = in_data ^ ks(mCtr);
         e.last = in_last | wrapErr;
         expQ.push_back(e);
         mCtr[CTR_W-1:0] = low + CTR_W'(1);
         if (in_last || wrapErr) mState = M_DRAIN;
         if (wrapErr) mErr = 1'b1;
      end
      if (!rst_n) begin
         mState = M_IDLE; mCtr = '0; mErr = 1'b0;
         holdData = '0; holdLast = 1'b0;
         expQ.delete();
      end else if (mState == M_IDLE && start) begin
         mCtr = iv; mErr = 1'b0; mState = M_RUN;
      end else if (mState == M_DRAIN && mDoneNow) begin
         mState = M_IDLE;
      end
      mDoneNow = 1'b0;
      @(posedge clk);
      edgeCnt++;
      @(negedge clk);
      if (out_valid === 1'b1) dutOuts++;
      if (expQ.size() > 0 && expQ[0].cyc == edgeCnt) begin
         e = expQ.pop_front();
         checkOutput("out_valid", out_valid, 1'b1);
         checkOutput("out_data", out_data, e.data);
         checkOutput("out_last", out_last, e.last);
         checkOutput("done", done, e.last);
         holdData = e.data; holdLast = e.last; mDoneNow = e.last;
      end else begin
         checkOutput("out_valid_idle", out_valid, 1'b0);
         checkOutput("done_idle", done, 1'b0);
         checkOutput("out_data_hold", out_data, holdData);
         checkOutput("out_last_hold", out_last, holdLast);
      end
      checkOutput("err", err, mErr);
   endtask

   task automatic runMsg(input logic [127:0] ivv, input logic [31:0] pat, input int nv,
                         input bit randPt, input bit randStart);
      int seen;
      dutOuts = 0;
      iv = ivv; start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      applyStimulus();
      start = 1'b0;
      seen = 0;
      for (int i = 0; i < 32 && seen < nv; i++) begin
         in_valid = pat[i];
         in_last  = pat[i] && (seen == nv - 1);
         in_data  = randPt ? rand128() : {16{8'hAA}};
         if (randStart) begin
            start = ($urandom_range(0, 3) == 0);
            iv    = rand128();
         end
         if (pat[i]) seen++;
         applyStimulus();
      end
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
      for (int w = 0; w < 60 && mState != M_IDLE; w++) applyStimulus();
      if (mState != M_IDLE) checkOutput("drain_timeout", 1'b0, 1'b1);
      applyStimulus();
   endtask

   initial begin
      vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 32'h1, 1, 1'b0, 1,
                  128'h000102030405060708090A0B0C0D0E10, 1'b0};
      vecs[1] = '{128'h0123456789ABCDEFFEDCBA9800000010, 32'hFFFF, 16, 1'b1, 16,
                  128'h0123456789ABCDEFFEDCBA9800000020, 1'b0};
      vecs[2] = '{128'h11112222333344445555666677770000, 32'h59, 4, 1'b1, 4,
                  128'h11112222333344445555666677770004, 1'b0};
`ifdef AES_CTR_WRAP_ERR_EN
      vecs[3] = '{128'hCAFEBABEDEADBEEF12345678FFFFFFFE, 32'h7, 3, 1'b1, 2,
                  128'hCAFEBABEDEADBEEF1234567800000000, 1'b1};
`else
      vecs[3] = '{128'hCAFEBABEDEADBEEF12345678FFFFFFFE, 32'h7, 3, 1'b1, 3,
                  128'hCAFEBABEDEADBEEF1234567800000001, 1'b0};
`endif

      // Reset held for three cycles with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start = 1'($urandom); in_valid = 1'($urandom); in_last = 1'($urandom);
         iv = rand128(); in_data = rand128();
         applyStimulus();
         chkOn = 1;
      end
      checkOutput("reset_busy", busy, 1'b0);
      checkOutput("reset_in_ready", in_ready, 1'b0);
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      repeat (3) applyStimulus();

      for (int v = 0; v < 4; v++) begin
         runMsg(vecs[v].iv, vecs[v].pat, vecs[v].nv, vecs[v].randPt, 1'b0);
         checkOutput($sformatf("vec%0d_outs", v), dutOuts, vecs[v].expOuts);
         checkOutput($sformatf("vec%0d_end_ctr", v), aes_in, vecs[v].expEnd);
         checkOutput($sformatf("vec%0d_err", v), err, vecs[v].expErr);
      end

      // Reset in the middle of a 10-block message after 5 accepts
      iv = rand128(); start = 1'b1;
      applyStimulus();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_last = 1'b0; in_data = rand128();
         applyStimulus();
      end
      in_valid = 1'b0; rst_n = 1'b0;
      applyStimulus();
      rst_n = 1'b1; dutOuts = 0;
      repeat (20) applyStimulus();
      checkOutput("post_reset_quiet", dutOuts, 0);
      runMsg(rand128(), 32'h1, 1, 1'b1, 1'b0);
      checkOutput("post_reset_msg_outs", dutOuts, 1);

      // Random messages with random gaps and ignored start pulses mid-message
      for (int m = 0; m < 20; m++) begin
         logic [127:0] rIv;
         rIv = rand128();
         if (m % 4 == 0) rIv[31:0] = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
         runMsg(rIv, $urandom | 32'hFF000000, $urandom_range(1, 8), 1'b1, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
